// File: rtl/text_console_pkg.sv
// Shared constants, control codes and state encoding for the text console and the
// LCD scan-out stage that reads the same character VRAM.
package text_console_pkg;

  localparam int COLS      = 60;
  localparam int ROWS      = 17;
  localparam int AW        = 10;
  localparam int VRAM_SIZE = COLS * ROWS;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;

  localparam logic [5:0]    LAST_COL    = 6'(COLS - 1);
  localparam logic [4:0]    LAST_ROW    = 5'(ROWS - 1);
  localparam logic [AW-1:0] ROW_STRIDE  = AW'(COLS);
  localparam logic [AW-1:0] LAST_ADDR   = AW'(VRAM_SIZE - 1);
  localparam logic [AW-1:0] SCROLL_LAST = AW'(COLS * (ROWS - 1) - 1);

  typedef enum logic [2:0] {
    RESET_CLR, IDLE, WRITE, WAIT_VS, SCR_RD, SCR_WR, CLR_LINE, CLR_ALL
  } state_t;

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    return AW'(row) * ROW_STRIDE + AW'(col);
  endfunction

  // 0x80..0xFF are glyph codes too and are stored unchanged.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b != 8'h7F);
  endfunction

endpackage

// File: rtl/text_console.sv
// Byte-stream front end for the 60x17 character VRAM: cursor handling, line wrap,
// vsync-aligned scroll and clear. Port-A outputs are registered, so each state's
// access appears on the port one cycle after the state itself.
module text_console
  import text_console_pkg::*;
(
  input  logic          PixelClk,
  input  logic          nRST,
  input  logic          ch_valid,
  input  logic [7:0]    ch_data,
  output logic          ch_ready,
  input  logic          vsync,
  output logic [AW-1:0] v_ada,
  output logic [7:0]    v_dina,
  output logic          v_wrea,
  input  logic [7:0]    v_douta,
  output logic [5:0]    cur_col,
  output logic [4:0]    cur_row,
  output logic          busy
);

  state_t        state, next_state;
  logic [AW-1:0] cnt;
  logic [7:0]    ch_q;
  logic          clr_pend;
  logic          vs_q;

  logic [AW-1:0] ada_d;
  logic [7:0]    dina_d, dina_q;
  logic          wrea_d, copy_d, copy_q;

  logic accept, vs_rise, printable, line_end, scroll_needed;

  assign accept        = ch_valid && ch_ready && (state == IDLE);
  assign vs_rise       = vsync && !vs_q;
  assign printable     = is_printable(ch_q);
  assign line_end      = (printable && cur_col == LAST_COL) || (ch_q == LF);
  assign scroll_needed = line_end && (cur_row == LAST_ROW);
  assign busy          = (state != IDLE);
  // During the scroll write cycle the data is the word read in the previous cycle.
  assign v_dina        = copy_q ? v_douta : dina_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) state <= RESET_CLR;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      RESET_CLR, CLR_ALL: if (cnt == LAST_ADDR) next_state = IDLE;
      IDLE:               if (accept) next_state = WRITE;
      WRITE:              next_state = (ch_q == FF || scroll_needed) ? WAIT_VS : IDLE;
      WAIT_VS:            if (vs_rise) next_state = clr_pend ? CLR_ALL : SCR_RD;
      SCR_RD:             next_state = SCR_WR;
      SCR_WR:             next_state = (cnt == SCROLL_LAST) ? CLR_LINE : SCR_RD;
      CLR_LINE:           if (cnt == LAST_ADDR) next_state = IDLE;
      default:            next_state = RESET_CLR;
    endcase
  end

  always_comb begin
    ada_d  = cnt;
    dina_d = BLANK;
    wrea_d = 1'b0;
    copy_d = 1'b0;
    case (state)
      RESET_CLR, CLR_ALL, CLR_LINE: wrea_d = 1'b1;
      WRITE: begin
        ada_d  = cell_addr(cur_row, cur_col);
        dina_d = ch_q;
        wrea_d = printable;
      end
      SCR_RD: ada_d = cnt + ROW_STRIDE;
      SCR_WR: begin
        wrea_d = 1'b1;
        copy_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      v_ada    <= '0;
      dina_q   <= BLANK;
      v_wrea   <= 1'b0;
      copy_q   <= 1'b0;
      ch_ready <= 1'b0;
    end else begin
      v_ada    <= ada_d;
      dina_q   <= dina_d;
      v_wrea   <= wrea_d;
      copy_q   <= copy_d;
      // Leaving WRITE keeps ready low one extra cycle: 2 low cycles per byte.
      ch_ready <= (next_state == IDLE) && (state != WRITE);
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      cnt      <= '0;
      ch_q     <= '0;
      clr_pend <= 1'b0;
      vs_q     <= 1'b0;
      cur_col  <= '0;
      cur_row  <= '0;
    end else begin
      vs_q <= vsync;
      if (accept) ch_q <= ch_data;
      case (state)
        RESET_CLR, CLR_ALL: begin
          if (cnt == LAST_ADDR) begin
            cnt      <= '0;
            cur_col  <= '0;
            cur_row  <= '0;
            clr_pend <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          cnt      <= '0;
          clr_pend <= (ch_q == FF);
          if (line_end) begin
            cur_col <= '0;
            if (cur_row != LAST_ROW) cur_row <= cur_row + 1'b1;
          end else if (printable) begin
            cur_col <= cur_col + 1'b1;
          end else if (ch_q == CR) begin
            cur_col <= '0;
          end else if (ch_q == BS && cur_col != '0) begin
            cur_col <= cur_col - 1'b1;
          end
        end
        SCR_WR: cnt <= cnt + 1'b1;
        CLR_LINE: cnt <= (cnt == LAST_ADDR) ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: a behavioural VRAM, a reference screen model
// and a write scoreboard fed by the model as each byte is sent.
module tb_text_console;
  import text_console_pkg::*;

  logic          PixelClk = 1'b0;
  logic          nRST     = 1'b0;
  logic          ch_valid = 1'b0;
  logic [7:0]    ch_data  = 8'h00;
  logic          vsync    = 1'b0;
  logic          ch_ready;
  logic [AW-1:0] v_ada;
  logic [7:0]    v_dina;
  logic          v_wrea;
  logic [7:0]    v_douta;
  logic [5:0]    cur_col;
  logic [4:0]    cur_row;
  logic          busy;

  logic [7:0]  vram    [0:1023];
  logic [7:0]  ref_mem [0:VRAM_SIZE-1];
  logic [17:0] exp_q   [$];
  int          checks  = 0;
  int          errors  = 0;
  bit          track   = 1'b1;
  int          exp_col = 0;
  int          exp_row = 0;

  text_console dut (
    .PixelClk(PixelClk), .nRST(nRST), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .vsync(vsync), .v_ada(v_ada), .v_dina(v_dina),
    .v_wrea(v_wrea), .v_douta(v_douta), .cur_col(cur_col), .cur_row(cur_row),
    .busy(busy)
  );

  always #5 PixelClk = ~PixelClk;

  // Single-port synchronous RAM, read-first, one cycle read latency.
  always @(posedge PixelClk) begin
    if (v_wrea) vram[v_ada] <= v_dina;
    v_douta <= vram[v_ada];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every DUT write is matched in order against the model's expected write.
  always @(negedge PixelClk) begin
    if (nRST && v_wrea && track) begin
      if (exp_q.size() == 0) check("sb_pending", 32'(exp_q.size()), 32'd1);
      else check("wr_addr_data", 32'({v_ada, v_dina}), 32'(exp_q.pop_front()));
    end
  end

  task automatic push_wr(input int addr, input logic [7:0] d);
    exp_q.push_back({10'(addr), d});
    ref_mem[addr] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < VRAM_SIZE; i++) push_wr(i, BLANK);
    exp_col = 0;
    exp_row = 0;
  endtask

  task automatic model_scroll();
    for (int i = 0; i < COLS * (ROWS - 1); i++) push_wr(i, ref_mem[i + COLS]);
    for (int i = COLS * (ROWS - 1); i < VRAM_SIZE; i++) push_wr(i, BLANK);
  endtask

  task automatic model_newline();
    exp_col = 0;
    if (exp_row == ROWS - 1) model_scroll();
    else exp_row++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b != 8'h7F) begin
      push_wr(exp_row * COLS + exp_col, b);
      if (exp_col == COLS - 1) model_newline();
      else exp_col++;
    end else if (b == LF) model_newline();
    else if (b == CR) exp_col = 0;
    else if (b == BS) begin
      if (exp_col > 0) exp_col--;
    end else if (b == FF) model_clear();
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic drive_byte(input logic [7:0] b);
    int guard = 0;
    while (!ch_ready && guard < 5000) begin
      @(negedge PixelClk);
      guard++;
    end
    check("ready_before_send", 32'(ch_ready), 32'd1);
    ch_data  = b;
    ch_valid = 1'b1;
    @(negedge PixelClk);
    ch_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    drive_byte(b);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!ch_ready && n < budget) begin
      @(negedge PixelClk);
      n++;
    end
    check(tag, 32'(ch_ready), 32'd1);
  endtask

  task automatic send_idle(input logic [7:0] b);
    send_byte(b);
    wait_ready("ready_after_byte", 20);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, 32'(cur_col), 32'(exp_col));
    check({tag, "_row"}, 32'(cur_row), 32'(exp_row));
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < VRAM_SIZE; i++)
      check($sformatf("%s[%0d]", tag, i), 32'(vram[i]), 32'(ref_mem[i]));
  endtask

  // Releases reset on a negedge and counts edges spent in the clear.
  task automatic release_and_clear(input string tag);
    int n = 0;
    nRST = 1'b1;
    while (busy && n < 3000) begin
      @(posedge PixelClk);
      #1;
      n++;
    end
    check({tag, "_cycles"}, 32'(n), 32'd1020);
    check({tag, "_ready"}, 32'(ch_ready), 32'd1);
    repeat (3) @(negedge PixelClk);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    compare_mem({tag, "_mem"});
    check_cursor(tag);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) vram[i] = 8'hEE;

    // Reset values while nRST is held low.
    repeat (3) @(negedge PixelClk);
    check("rst_col", 32'(cur_col), 32'd0);
    check("rst_row", 32'(cur_row), 32'd0);
    check("rst_wrea", 32'(v_wrea), 32'd0);
    check("rst_ada", 32'(v_ada), 32'd0);
    check("rst_dina", 32'(v_dina), 32'h20);
    check("rst_ready", 32'(ch_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    model_clear();
    release_and_clear("reset_clr");

    // "AB": two writes, ready low for exactly two cycles after each acceptance.
    for (int k = 0; k < 2; k++) begin
      send_byte(8'h41 + 8'(k));
      check("ready_t1", 32'(ch_ready), 32'd0);
      check("busy_t1", 32'(busy), 32'd1);
      @(negedge PixelClk);
      check("ready_t2", 32'(ch_ready), 32'd0);
      check("busy_t2", 32'(busy), 32'd0);
      @(negedge PixelClk);
      check("ready_t3", 32'(ch_ready), 32'd1);
    end
    check_cursor("after_ab");

    // Put distinctive text on row 1, then fill row 3 to its last column.
    send_idle(LF);
    send_idle("h");
    send_idle("i");
    send_idle(LF);
    send_idle(LF);
    check_cursor("row3");
    for (int k = 0; k < COLS - 1; k++) send_idle(8'h61 + 8'(k % 26));
    check_cursor("col59");
    send_idle("Z");
    check_cursor("wrap");
    check("wrap_no_scroll", 32'(busy), 32'd0);
    check("z_at_239", 32'(vram[239]), 32'h5A);

    // BS at column 0, BS mid-line, CR, ignored codes and a raw high byte.
    send_idle(LF);
    send_idle(BS);
    check_cursor("bs_col0");
    check("bs_no_write", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 7; k++) send_idle(8'h30 + 8'(k));
    send_idle(BS);
    check_cursor("bs_col7");
    send_idle(CR);
    check_cursor("cr");
    send_idle(8'h7F);
    send_idle(8'h01);
    check_cursor("ignored");
    send_idle(8'h80);
    check_cursor("raw_high");
    check("raw_high_300", 32'(vram[300]), 32'h80);

    // Scroll from the last row, with vsync already high on entry to WAIT_VS.
    for (int k = 0; k < 11; k++) send_idle(LF);
    check_cursor("row16");
    send_idle("Q");
    vsync = 1'b1;
    send_byte(LF);
    repeat (20) @(negedge PixelClk);
    check("vs_level_busy", 32'(busy), 32'd1);
    check("vs_level_no_copy", 32'(exp_q.size()), 32'(VRAM_SIZE));
    vsync = 1'b0;
    repeat (5) @(negedge PixelClk);
    vsync = 1'b1;
    n = 0;
    forever begin
      @(negedge PixelClk);
      if (!busy || n >= 5000) break;
      n++;
    end
    check("scroll_cycles", 32'(n), 32'd1980);
    check("scroll_ready", 32'(ch_ready), 32'd1);
    repeat (2) @(negedge PixelClk);
    check("scroll_sb_empty", 32'(exp_q.size()), 32'd0);
    check("scroll_row1_to_0", 32'(vram[0]), 32'h68);
    check("scroll_row16_to_15", 32'(vram[900]), 32'h51);
    check("scroll_last_blank", 32'(vram[960]), 32'h20);
    compare_mem("scroll_mem");
    check_cursor("scroll");

    // FF aborted by reset 500 cycles into the clear; a full reset clear follows.
    vsync = 1'b0;
    track = 1'b0;
    drive_byte(FF);
    repeat (5) @(negedge PixelClk);
    check("ff_wait_busy", 32'(busy), 32'd1);
    vsync = 1'b1;
    repeat (500) @(negedge PixelClk);
    check("ff_clear_busy", 32'(busy), 32'd1);
    nRST = 1'b0;
    @(negedge PixelClk);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_ready", 32'(ch_ready), 32'd0);
    check("abort_wrea", 32'(v_wrea), 32'd0);
    exp_q.delete();
    model_clear();
    track = 1'b1;
    vsync = 1'b0;
    @(negedge PixelClk);
    release_and_clear("abort_clr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
